// File: rtl/img_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : img_arb_pkg
//  Brief    : Shared types and default sizes for the image memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package img_arb_pkg;

    // Default sizes; the arbiter exposes them as overridable parameters.
    localparam int ADDR_W_DEF   = 24;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;

    // Who owns the read data returning from memory this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_counter
//  Brief    : Counts consecutive denied CPU cycles and raises a force flag
//             once the CPU has waited MAX_WAIT edges. Used by img_mem_arbiter
//             only when IMG_ARB_STARVE_GUARD_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_starve_counter
    import img_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic cpu_req_i,
    input  logic cpu_gnt_i,
    output logic force_o
);

    // A zero-wait guard still needs a one-bit counter to elaborate.
    localparam int               CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating count of denied edges; any grant or dropped request restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (!cpu_req_i || cpu_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag is purely registered, so it cannot form a loop with the grant logic.
    assign force_o = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/img_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : img_mem_arbiter
//  Brief    : Shares the single-port image memory between the CPU load/store
//             path and the VGA pixel fetch. VGA has priority; read data is
//             routed back to its owner one cycle after the grant.
//  Options  : IMG_ARB_STARVE_GUARD_EN - when defined, a CPU denied MAX_WAIT
//             consecutive cycles wins the next contended cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module img_mem_arbiter
    import img_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    // CPU port
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    // VGA port (read only)
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_adr_i,
    output logic              vga_gnt_o,
    output logic              vga_rvalid_o,
    output logic [DATA_W-1:0] vga_rdata_o,
    // Memory port
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    owner_t last_own_q;
    owner_t last_own_d;
    logic   force_cpu;

`ifdef IMG_ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .cpu_req_i (cpu_req_i),
        .cpu_gnt_i (cpu_gnt_o),
        .force_o   (force_cpu)
    );
`else
    // Fixed VGA priority: MAX_WAIT has no effect in this build.
    logic [31:0] max_wait_unused;
    assign max_wait_unused = 32'(MAX_WAIT);
    assign force_cpu       = 1'b0;
`endif

    // VGA wins contention unless the starvation guard is forcing the CPU.
    assign cpu_gnt_o = cpu_req_i && (!vga_req_i || force_cpu);
    assign vga_gnt_o = vga_req_i && !cpu_gnt_o;

    // Memory steering; idle cycles park the address on the CPU side.
    assign mem_adr_o   = vga_gnt_o ? vga_adr_i : cpu_adr_i;
    assign mem_wdata_o = cpu_wdata_i;
    assign mem_we_o    = cpu_gnt_o && cpu_we_i;

    // Owner of the data that memory returns next cycle; writes return nothing.
    always_comb begin
        last_own_d = OWN_NONE;
        if (cpu_gnt_o && !cpu_we_i) begin
            last_own_d = OWN_CPU;
        end else if (vga_gnt_o) begin
            last_own_d = OWN_VGA;
        end
    end

    // Owner register; reset drops any in-flight read immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_own_q <= OWN_NONE;
        end else begin
            last_own_q <= last_own_d;
        end
    end

    // Both ports see the raw memory data; rvalid alone tells them whose it is.
    assign cpu_rvalid_o = (last_own_q == OWN_CPU);
    assign vga_rvalid_o = (last_own_q == OWN_VGA);
    assign cpu_rdata_o  = mem_rdata_i;
    assign vga_rdata_o  = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_img_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_img_mem_arbiter
//  Brief    : Self-checking bench for img_mem_arbiter. A behavioural model
//             (request rules, denied-streak count, reference memory and a
//             pending-read record) is compared on every falling edge; directed
//             sequences pin the model with literal expectations, then a
//             randomized protocol-respecting phase runs. Honours
//             IMG_ARB_STARVE_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_img_mem_arbiter;

    localparam int AW    = 24;
    localparam int DW    = 8;
    localparam int MW    = 4;
    localparam int MEM_N = 64;

`ifdef IMG_ARB_STARVE_GUARD_EN
    localparam int EXP_FIRST = 5;
    localparam int EXP_CPU   = 20;
`else
    localparam int EXP_FIRST = 0;
    localparam int EXP_CPU   = 0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          cpu_req_i, cpu_we_i;
    logic [AW-1:0] cpu_adr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          cpu_gnt_o, cpu_rvalid_o;
    logic [DW-1:0] cpu_rdata_o;
    logic          vga_req_i;
    logic [AW-1:0] vga_adr_i;
    logic          vga_gnt_o, vga_rvalid_o;
    logic [DW-1:0] vga_rdata_o;
    logic [AW-1:0] mem_adr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_arr [MEM_N];
    logic [DW-1:0] ref_mem [MEM_N];

    // Model state: 0 = no read in flight, 1 = CPU, 2 = VGA.
    int            pend_owner = 0;
    logic [DW-1:0] pend_data  = '0;
    int            streak     = 0;

    bit cpu_hold = 1'b0;
    bit vga_hold = 1'b0;

    img_mem_arbiter dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_adr_i    (cpu_adr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_gnt_o    (cpu_gnt_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .vga_req_i    (vga_req_i),
        .vga_adr_i    (vga_adr_i),
        .vga_gnt_o    (vga_gnt_o),
        .vga_rvalid_o (vga_rvalid_o),
        .vga_rdata_o  (vga_rdata_o),
        .mem_adr_o    (mem_adr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous single-port memory seen by the arbiter.
    always @(posedge clk_i) begin
        if (mem_we_o) mem_arr[mem_adr_o[5:0]] <= mem_wdata_o;
        mem_rdata_i <= mem_arr[mem_adr_o[5:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Any reset discards the read the model was expecting.
    always @(posedge reset_i) begin
        pend_owner = 0;
        streak     = 0;
    end

    // Reference model and per-cycle compare.
    always @(negedge clk_i) begin : model
        bit ec, ev, frc;
        if (reset_i) begin
            pend_owner = 0;
            streak     = 0;
            check("m_rst_cpu_rvalid", 32'(cpu_rvalid_o), 0);
            check("m_rst_vga_rvalid", 32'(vga_rvalid_o), 0);
        end else begin
`ifdef IMG_ARB_STARVE_GUARD_EN
            frc = (streak >= MW);
`else
            frc = 1'b0;
`endif
            ec = cpu_req_i && (!vga_req_i || frc);
            ev = vga_req_i && !ec;
            check("m_cpu_gnt", 32'(cpu_gnt_o), 32'(ec));
            check("m_vga_gnt", 32'(vga_gnt_o), 32'(ev));
            check("m_mem_we", 32'(mem_we_o), 32'(ec && cpu_we_i));
            check("m_mem_adr", 32'(mem_adr_o), 32'(ev ? vga_adr_i : cpu_adr_i));
            check("m_mem_wdata", 32'(mem_wdata_o), 32'(cpu_wdata_i));
            check("m_cpu_rvalid", 32'(cpu_rvalid_o), 32'(pend_owner == 1));
            check("m_vga_rvalid", 32'(vga_rvalid_o), 32'(pend_owner == 2));
            if (pend_owner != 0) begin
                check("m_cpu_rdata", 32'(cpu_rdata_o), 32'(pend_data));
                check("m_vga_rdata", 32'(vga_rdata_o), 32'(pend_data));
            end
            if (ec) begin
                if (cpu_we_i) begin
                    ref_mem[cpu_adr_i[5:0]] = cpu_wdata_i;
                    pend_owner = 0;
                end else begin
                    pend_owner = 1;
                    pend_data  = ref_mem[cpu_adr_i[5:0]];
                end
            end else if (ev) begin
                pend_owner = 2;
                pend_data  = ref_mem[vga_adr_i[5:0]];
            end else begin
                pend_owner = 0;
            end
            if (!cpu_req_i || ec) streak = 0;
            else if (streak < MW) streak++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        vga_req_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int first, ncpu, nvga;
        int pc_tab [4] = '{30, 70, 95, 50};
        int pv_tab [4] = '{90, 50, 100, 20};

        for (int i = 0; i < MEM_N; i++) begin
            mem_arr[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            mem_arr[i] = 8'(i + 1);
            ref_mem[i] = 8'(i + 1);
        end

        reset_i     = 1'b1;
        cpu_adr_i   = '0;
        cpu_wdata_i = '0;
        vga_adr_i   = '0;
        idle();
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("reset_cpu_rvalid", 32'(cpu_rvalid_o), 0);
        check("reset_vga_rvalid", 32'(vga_rvalid_o), 0);

        // CPU write 0xA5 to 0x10, then read it back.
        tick();
        cpu_req_i = 1; cpu_we_i = 1; cpu_adr_i = 24'h000010; cpu_wdata_i = 8'hA5;
        @(negedge clk_i);
        check("wr_cpu_gnt", 32'(cpu_gnt_o), 1);
        check("wr_mem_we", 32'(mem_we_o), 1);
        check("wr_mem_adr", 32'(mem_adr_o), 32'h10);
        tick();
        cpu_we_i = 0;
        @(negedge clk_i);
        check("rd_cpu_gnt", 32'(cpu_gnt_o), 1);
        check("rd_mem_we", 32'(mem_we_o), 0);
        tick();
        idle();
        @(negedge clk_i);
        check("rd_cpu_rvalid", 32'(cpu_rvalid_o), 1);
        check("rd_cpu_rdata", 32'(cpu_rdata_o), 32'hA5);
        check("rd_vga_rvalid", 32'(vga_rvalid_o), 0);

        // Single-cycle contention.
        tick();
        cpu_req_i = 1; cpu_we_i = 0; cpu_adr_i = 24'h000005;
        vga_req_i = 1; vga_adr_i = 24'h000002;
        @(negedge clk_i);
        check("cont_vga_gnt", 32'(vga_gnt_o), 1);
        check("cont_cpu_gnt", 32'(cpu_gnt_o), 0);
        tick();
        vga_req_i = 0;
        @(negedge clk_i);
        check("cont_cpu_gnt2", 32'(cpu_gnt_o), 1);
        check("cont_vga_rvalid", 32'(vga_rvalid_o), 1);
        check("cont_vga_rdata", 32'(vga_rdata_o), 32'h03);
        tick();
        idle();
        @(negedge clk_i);
        check("cont_vga_rvalid_once", 32'(vga_rvalid_o), 0);
        check("cont_cpu_rvalid", 32'(cpu_rvalid_o), 1);

        // Back-to-back VGA reads of 0..3.
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                vga_req_i = 1;
                vga_adr_i = 24'(i);
            end else begin
                idle();
            end
            @(negedge clk_i);
            if (i >= 1 && i <= 4) begin
                check("b2b_vga_rvalid", 32'(vga_rvalid_o), 1);
                check("b2b_vga_rdata", 32'(vga_rdata_o), 32'(i));
            end else if (i == 5) begin
                check("b2b_vga_rvalid_end", 32'(vga_rvalid_o), 0);
            end
        end

        // Reset across the accept edge of a VGA read.
        tick();
        vga_req_i = 1; vga_adr_i = 24'h000001;
        @(negedge clk_i);
        check("mid_vga_gnt", 32'(vga_gnt_o), 1);
        #2 reset_i = 1'b1;
        tick();
        idle();
        cpu_req_i = 1; cpu_we_i = 0; cpu_adr_i = 24'h000003;
        check("mid_vga_rvalid_rst", 32'(vga_rvalid_o), 0);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("mid_cpu_gnt", 32'(cpu_gnt_o), 1);
        check("mid_vga_rvalid", 32'(vga_rvalid_o), 0);
        tick();
        idle();
        @(negedge clk_i);
        check("mid_cpu_rvalid", 32'(cpu_rvalid_o), 1);
        check("mid_cpu_rdata", 32'(cpu_rdata_o), 32'h04);

        // Reset clears a visible rvalid without waiting for a clock.
        tick();
        vga_req_i = 1; vga_adr_i = 24'h000002;
        tick();
        idle();
        check("async_vga_rvalid_pre", 32'(vga_rvalid_o), 1);
        check("async_vga_rdata_pre", 32'(vga_rdata_o), 32'h03);
        #1 reset_i = 1'b1;
        #1 check("async_vga_rvalid", 32'(vga_rvalid_o), 0);
        tick();
        reset_i = 1'b0;

        // Continuous VGA traffic against a waiting CPU.
        tick();
        idle();
        tick();
        cpu_req_i = 1; cpu_we_i = 0; cpu_adr_i = 24'h000007;
        vga_req_i = 1; vga_adr_i = 24'h000009;
        first = 0; ncpu = 0; nvga = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk_i);
            if (cpu_gnt_o && first == 0) first = c;
            ncpu += int'(cpu_gnt_o);
            nvga += int'(vga_gnt_o);
            if (c == 5) check("starve_vga_gnt_c5", 32'(vga_gnt_o), 32'(EXP_FIRST != 5));
            if (c == 6) check("starve_vga_gnt_c6", 32'(vga_gnt_o), 1);
            tick();
        end
        check("starve_first_cpu", 32'(first), 32'(EXP_FIRST));
        check("starve_cpu_count", 32'(ncpu), 32'(EXP_CPU));
        check("starve_vga_count", 32'(nvga), 32'(100 - EXP_CPU));
        idle();

        // Randomized traffic; requesters hold until granted.
        for (int n = 0; n < 3000; n++) begin
            int ph;
            tick();
            ph = (n / 750) % 4;
            if (!cpu_hold) begin
                cpu_req_i   = ($urandom_range(0, 99) < pc_tab[ph]);
                cpu_we_i    = $urandom_range(0, 1) == 1;
                cpu_adr_i   = 24'($urandom);
                cpu_wdata_i = 8'($urandom);
            end
            if (!vga_hold) begin
                vga_req_i = ($urandom_range(0, 99) < pv_tab[ph]);
                vga_adr_i = 24'($urandom);
            end
            @(negedge clk_i);
            cpu_hold = cpu_req_i && !cpu_gnt_o;
            vga_hold = vga_req_i && !vga_gnt_o;
        end

        tick();
        idle();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
